tx_serial_param: RTL and testbench
==================================

Name: tx_serial_param

Overview:
Parametrised asynchronous serial (UART) transmitter, successor to the fixed 7O1 transmitter.
- Frame format (data width, parity mode, stop-bit count) and baud divisor are set at elaboration.
- Contains its own FSM, frame shift register, bit counter and baud tick divider.
- Sits between a character source (keyboard/ASCII logic) and a GPIO serial output pin.

Parameters:
DATA_BITS, 7, data bits per frame, legal 5..9, sent LSB first
PARITY, 2, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, 1 or 2
DIVISOR, 434, clock cycles per bit (50 MHz / 115200); legal >= 2
DIV_W, 9, tick counter width; 2^DIV_W >= DIVISOR

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
partida  in  1  start request; level-sampled in IDLE only
dados  in  DATA_BITS  character to send; captured in the accept cycle
saida_serial  out  1  serial line; idle high
pronto  out  1  one-cycle pulse at end of last stop bit
ocupado  out  1  high from LOAD through DONE inclusive
db_tick  out  1  baud tick, for debug
db_estado  out  4  state code, for debug

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high; every register clears on the reset edge.
- Reset values: saida_serial=1, pronto=0, ocupado=0, db_estado=0000, tick counter=0, bit counter=0.
- Frame length: FRAME_W = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- Frame order: start(0), d[0]..d[DATA_BITS-1], parity, stop(1)xSTOP_BITS.
- Parity bit:
  - even: XOR of the data bits.
  - odd: inverted XOR of the data bits.
  - none: bit omitted.
- FSM states (db_estado):
  - IDLE 0000: saida=1. partida=1 at an edge -> LOAD.
  - LOAD 0001: builds the frame into the shift register (LSB = start bit) and captures dados. Clears the tick counter and bit counter. Next edge -> SEND.
  - SEND 0010: saida_serial = shift register LSB, registered, so there are no glitches.
    - Tick counter counts 0..DIVISOR-1; tick = (count == DIVISOR-1).
    - On each tick: shift right, filling with 1, and increment the bit counter.
    - On the tick where bit counter == FRAME_W-1 -> DONE.
  - DONE 1111: pronto=1 for exactly this one cycle; saida=1. Next edge -> IDLE.
  - Unused codes -> IDLE.
- Latency:
  - partida sampled at edge k -> LOAD during cycle k..k+1.
  - Start bit appears on saida at edge k+2.
  - Every bit lasts exactly DIVISOR cycles.
  - pronto is asserted at edge k+2+FRAME_W*DIVISOR.
  - The earliest next start bit follows 3 cycles after pronto rises, if partida is held high.
- Handshake:
  - partida is ignored outside IDLE.
  - Holding partida high gives back-to-back frames separated by DONE, IDLE and LOAD (each 1 cycle, saida=1).
  - Changes on dados after LOAD do not affect the frame in flight.
- Tick counter: runs only in SEND and is held at 0 elsewhere. db_tick mirrors the tick.
- Reset mid-frame: next cycle saida=1, state IDLE, no pronto pulse; the remaining bits are discarded.
- Reset and partida asserted in the same cycle: reset wins.
- Width rules:
  - Bit counter is ceil(log2(FRAME_W+1)) bits and does not wrap within a frame.
  - Tick counter wraps to 0 on tick.

Test Plan:
1. Defaults (7O1), DIVISOR=4, dados=7'h35, pulse partida 1 cycle -> saida sequence 0,1,0,1,0,1,1,0,1,1, each bit 4 cycles; pronto at cycle 2+40; ocupado high cycles 1..42.
2. PARITY=1, DATA_BITS=8, STOP_BITS=2, dados=8'hA5 -> frame 0,1,0,1,0,0,1,0,1,0,1,1 (parity 0, two stops); 12 bits x DIVISOR.
3. PARITY=0, DATA_BITS=5, dados=5'h1F -> frame 0,1,1,1,1,1,1 (7 bits, no parity bit); pronto after 7*DIVISOR+2 cycles.
4. Hold partida high, dados changed from 7'h41 to 7'h42 mid-frame -> first frame carries 0x41; second frame carries 0x42 with its start bit 3 cycles after the first pronto.
5. Assert reset for 1 cycle in the middle of data bit 3 -> saida=1 and db_estado=0000 the next cycle; no pronto; a subsequent partida sends a correct full frame.
6. Assert partida while in SEND -> frame timing unchanged; no extra frame after pronto if partida has dropped.

Source files
------------

// File: rtl/tx_serial_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional even/odd parity and one or two stop bits, one bit every DIVISOR clocks.
module tx_serial_param #(
  parameter int unsigned DATA_BITS = 7,
  parameter int unsigned PARITY    = 2,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DIVISOR   = 434,
  parameter int unsigned DIV_W     = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 partida,
  input  logic [DATA_BITS-1:0] dados,
  output logic                 saida_serial,
  output logic                 pronto,
  output logic                 ocupado,
  output logic                 db_tick,
  output logic [3:0]           db_estado
);

  localparam int unsigned PAR_W   = (PARITY != 0) ? 1 : 0;
  localparam int unsigned FRAME_W = 1 + DATA_BITS + PAR_W + STOP_BITS;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [3:0] S_IDLE = 4'b0000;
  localparam logic [3:0] S_LOAD = 4'b0001;
  localparam logic [3:0] S_SEND = 4'b0010;
  localparam logic [3:0] S_DONE = 4'b1111;

  logic [3:0]         state_q,    state_d;
  logic [FRAME_W-1:0] shift_q,    shift_d;
  logic [DIV_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic               saida_q,    saida_d;
  logic               pronto_q,   pronto_d;
  logic               ocupado_q,  ocupado_d;
  logic               tick_q,     tick_d;

  logic               par_bit_c;
  logic [FRAME_W-1:0] frame_c;
  logic               tick_c;
  logic               last_bit_c;

  // Frame image with the start bit in the LSB; stop bits come from the all-ones default
  always_comb begin
    par_bit_c = (PARITY == 1) ? (^dados) : ~(^dados);
    frame_c              = '1;
    frame_c[0]           = 1'b0;
    frame_c[DATA_BITS:1] = dados;
    if (PARITY != 0) begin
      frame_c[DATA_BITS+1] = par_bit_c;
    end
  end

  assign tick_c     = (state_q == S_SEND) && (tick_cnt_q == DIV_W'(DIVISOR - 1));
  assign last_bit_c = (bit_cnt_q == CNT_W'(FRAME_W - 1));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tick_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (partida) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d   = frame_c;
        bit_cnt_d = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + DIV_W'(1);
        if (tick_c) begin
          shift_d   = {1'b1, shift_q[FRAME_W-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (last_bit_c) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line and status flags are registered from the current state, so they trail it by one clock
  always_comb begin
    saida_d   = (state_q == S_SEND) ? shift_q[0] : 1'b1;
    pronto_d  = (state_q == S_DONE);
    ocupado_d = (state_q == S_LOAD) || (state_q == S_SEND) || (state_q == S_DONE);
    tick_d    = tick_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      saida_q    <= 1'b1;
      pronto_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      saida_q    <= saida_d;
      pronto_q   <= pronto_d;
      ocupado_q  <= ocupado_d;
      tick_q     <= tick_d;
    end
  end

  assign saida_serial = saida_q;
  assign pronto       = pronto_q;
  assign ocupado      = ocupado_q;
  assign db_tick      = tick_q;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_tx_serial_param.sv
// Bench for tx_serial_param: three frame formats (7O1, 8E2, 5N1) driven in turn
// and compared cycle by cycle against a frame model built from the data.
module tb_tx_serial_param;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      partida;
  logic [2:0][8:0] dados;
  logic [2:0]      saida;
  logic [2:0]      pronto;
  logic [2:0]      ocupado;
  logic [2:0]      tick;
  logic [2:0][3:0] est;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tx_serial_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DIVISOR(4), .DIV_W(4)) u_7o1 (
    .clock(clk), .reset(rst), .partida(partida[0]), .dados(dados[0][6:0]),
    .saida_serial(saida[0]), .pronto(pronto[0]), .ocupado(ocupado[0]),
    .db_tick(tick[0]), .db_estado(est[0]));

  tx_serial_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .DIVISOR(3), .DIV_W(4)) u_8e2 (
    .clock(clk), .reset(rst), .partida(partida[1]), .dados(dados[1][7:0]),
    .saida_serial(saida[1]), .pronto(pronto[1]), .ocupado(ocupado[1]),
    .db_tick(tick[1]), .db_estado(est[1]));

  tx_serial_param #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .DIVISOR(5), .DIV_W(4)) u_5n1 (
    .clock(clk), .reset(rst), .partida(partida[2]), .dados(dados[2][4:0]),
    .saida_serial(saida[2]), .pronto(pronto[2]), .ocupado(ocupado[2]),
    .db_tick(tick[2]), .db_estado(est[2]));

  function automatic int db_of(input int d);
    case (d)
      0:       return 7;
      1:       return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int par_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int sb_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int dv_of(input int d);
    case (d)
      0:       return 4;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  // Reference frame as a bit list: start, data LSB first, parity, stops (idle ones beyond)
  function automatic void build(input int d, input logic [8:0] data,
                                output logic [15:0] fr, output int fw);
    int ones;
    ones = 0;
    fr   = '1;
    fr[0] = 1'b0;
    fw   = 1;
    for (int i = 0; i < db_of(d); i++) begin
      fr[4'(fw)] = data[i];
      if (data[i]) ones++;
      fw++;
    end
    if (par_of(d) == 1) begin
      fr[4'(fw)] = ((ones % 2) == 1);
      fw++;
    end else if (par_of(d) == 2) begin
      fr[4'(fw)] = ((ones % 2) == 0);
      fw++;
    end
    fw += sb_of(d);
  endfunction

  task automatic chk(input string tag, input int d, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, d, $time, obs, exp);
    end
  endtask

  // Sends one frame; mode 1 changes dados mid-frame, mode 2 pulses partida mid-frame
  task automatic frame(input int d, input logic [8:0] data, input bit hold,
                       input int mode, input logic [8:0] alt);
    logic [15:0] fr;
    int fw, dv, last, nt;
    logic exp_s;
    build(d, data, fr, fw);
    dv   = dv_of(d);
    last = fw * dv + 2;
    nt   = 0;
    partida[d] = 1'b1;
    dados[d]   = data;
    @(posedge clk);
    @(negedge clk);
    chk("load_state", d, 16'(est[d]), 16'h1);
    chk("ocupado_n0", d, 16'(ocupado[d]), 16'h0);
    if (!hold) partida[d] = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      @(negedge clk);
      exp_s = (n < 2) ? 1'b1 : fr[4'((n - 2) / dv)];
      chk("saida", d, 16'(saida[d]), 16'(exp_s));
      chk("pronto", d, 16'(pronto[d]), 16'(n == last));
      chk("ocupado", d, 16'(ocupado[d]), 16'h1);
      nt += int'(tick[d]);
      if (mode == 1 && n == last / 2) dados[d] = alt;
      if (mode == 2 && n == last / 2) partida[d] = 1'b1;
      if (mode == 2 && n == last / 2 + 3) partida[d] = 1'b0;
    end
    chk("tick_count", d, 16'(nt), 16'(fw));
  endtask

  task automatic idle_check(input int d, input int cycles);
    int np, nz;
    np = 0;
    nz = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      np += int'(pronto[d]);
      if (est[d] != 4'h0 || saida[d] != 1'b1 || ocupado[d] != 1'b0) nz++;
    end
    chk("idle_pronto", d, 16'(np), 16'h0);
    chk("idle_line", d, 16'(nz), 16'h0);
  endtask

  initial begin
    logic [8:0] r1, r2;
    int d, h;

    rst     = 1'b1;
    partida = '0;
    dados   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_saida", i, 16'(saida[i]), 16'h1);
      chk("rst_pronto", i, 16'(pronto[i]), 16'h0);
      chk("rst_ocupado", i, 16'(ocupado[i]), 16'h0);
      chk("rst_estado", i, 16'(est[i]), 16'h0);
      chk("rst_tick", i, 16'(tick[i]), 16'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    frame(0, 9'h035, 1'b0, 0, 9'h000);
    frame(1, 9'h0A5, 1'b0, 0, 9'h000);
    frame(2, 9'h01F, 1'b0, 0, 9'h000);

    // Back-to-back frames with dados changing under the first one
    frame(0, 9'h041, 1'b1, 1, 9'h042);
    frame(0, 9'h042, 1'b0, 0, 9'h000);
    idle_check(0, 5);

    // Reset in the middle of data bit 3
    partida[0] = 1'b1;
    dados[0]   = 9'h035;
    @(posedge clk);
    @(negedge clk);
    partida[0] = 1'b0;
    for (int n = 1; n <= 2 + 4 * dv_of(0) + 1; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_bit3", 0, 16'(saida[0]), 16'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_saida", 0, 16'(saida[0]), 16'h1);
    chk("midrst_estado", 0, 16'(est[0]), 16'h0);
    chk("midrst_pronto", 0, 16'(pronto[0]), 16'h0);
    idle_check(0, 50);
    frame(0, 9'h05A, 1'b0, 0, 9'h000);

    // partida during SEND is ignored
    frame(1, 9'($urandom), 1'b0, 2, 9'h000);
    idle_check(1, 20);

    for (int i = 0; i < 8; i++) begin
      d  = int'($urandom_range(0, 2));
      h  = int'($urandom_range(0, 1));
      r1 = 9'($urandom);
      r2 = 9'($urandom);
      frame(d, r1, h[0], 1, r2);
      if (h != 0) frame(d, r2, 1'b0, 0, 9'h000);
      idle_check(d, 3);
    end

    // Reset wins over a simultaneous start request
    rst        = 1'b1;
    partida[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_vs_partida", 0, 16'(est[0]), 16'h0);
    rst        = 1'b0;
    partida[0] = 1'b0;
    idle_check(0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
